// File: rtl/instr_aligner_pkg.sv
// instr_aligner_pkg: constants shared by the fetch-side instruction aligner,
// fetch and decode.
package instr_aligner_pkg;
    localparam int          PC_WIDTH_DEF  = 24;
    localparam int          INSTR_LEN_BIT = 15;
    localparam logic        IDLE          = 1'b0;
    localparam logic        HALF          = 1'b1;
    localparam logic [15:0] HALF_ZERO     = 16'h0000;
endpackage

// File: rtl/instr_aligner.sv
// instr_aligner: assembles 16-bit code words into 16/32-bit instructions
// for decode, tracking the word-address PC of each emitted instruction.
module instr_aligner
    import instr_aligner_pkg::*;
#(
    parameter int                  PC_WIDTH = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         in_word,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    input  logic [PC_WIDTH-1:0] flush_pc,
    output logic [31:0]         out_instr,
    output logic                out_is32,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic                out_valid,
    input  logic                out_ready
);
    logic                r_state;
    logic                w_state_nxt;
    logic [15:0]         r_hold;
    logic [PC_WIDTH-1:0] r_hold_pc;
    logic [PC_WIDTH-1:0] r_next_pc;
    logic                w_acc;
    logic                w_long;
    logic                w_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush)      w_state_nxt = IDLE;
        else if (w_acc) w_state_nxt = (r_state == IDLE && w_long) ? HALF : IDLE;
    end

    // in_ready ignores in_valid so fetch can rely on it combinationally
    always_comb begin
        in_ready = !flush && (!out_valid || out_ready);
        w_acc    = in_valid && in_ready;
        w_long   = in_word[INSTR_LEN_BIT];
        w_done   = w_acc && (r_state == HALF || !w_long);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_is32  <= 1'b0;
            out_pc    <= '0;
            r_hold    <= '0;
            r_hold_pc <= '0;
            r_next_pc <= RESET_PC;
        end else if (flush) begin
            out_valid <= 1'b0;
            r_next_pc <= flush_pc;
        end else begin
            if (w_acc) r_next_pc <= r_next_pc + PC_WIDTH'(1);
            if (w_acc && r_state == IDLE && w_long) begin
                r_hold    <= in_word;
                r_hold_pc <= r_next_pc;
            end
            if (w_done) begin
                out_valid <= 1'b1;
                out_instr <= (r_state == HALF) ? {r_hold, in_word} : {in_word, HALF_ZERO};
                out_is32  <= (r_state == HALF);
                out_pc    <= (r_state == HALF) ? r_hold_pc : r_next_pc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
